// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and forwarding controller for the in-order pipeline. A table of
//   DEPTH entries {valid, rd, load} follows every in-flight register write
//   from E (stage 1) down to W (stage DEPTH). The table drives load-use
//   stalls, branch flushes and per-operand forwarding selects.
//
//   Optional feature: define HAZARD_SB_MULTICYCLE_EN to build the multi-cycle
//   execute counter. This counter holds E for MC_LAT cycles. With the macro
//   undefined, mc_d is ignored and mc_busy/stall_e are tied low.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-low reset
//   issue_valid           decode holds a valid instruction
//   rs1_d, rs2_d, rd_d    decode source/destination registers
//   regwrite_d, load_d    decode writes rd / result comes from memory
//   mc_d                  decode instruction is a multi-cycle execute op
//   rs1_e, rs2_e          execute-stage source registers
//   pcsrc_e               taken branch/redirect resolved in E
//   stall_f, stall_d      hold PC / hold IF-ID
//   flush_d, flush_e      clear IF-ID / clear ID-EX
//   stall_e               hold ID-EX, bubble into M
//   fwd_a_e, fwd_b_e      0 = register file, k = forward from stage k+1
//   mc_busy               multi-cycle op occupying E
module hazard_scoreboard #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned AW         = 5,
  parameter int unsigned LOAD_AVAIL = 3,
  parameter int unsigned MC_LAT     = 4,
  parameter int unsigned FW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] rs1_d,
  input  logic [AW-1:0] rs2_d,
  input  logic [AW-1:0] rd_d,
  input  logic          regwrite_d,
  input  logic          load_d,
  input  logic          mc_d,
  input  logic [AW-1:0] rs1_e,
  input  logic [AW-1:0] rs2_e,
  input  logic          pcsrc_e,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_d,
  output logic          flush_e,
  output logic          stall_e,
  output logic [FW-1:0] fwd_a_e,
  output logic [FW-1:0] fwd_b_e,
  output logic          mc_busy
);

  // In-flight write table, index 1 = E ... DEPTH = W
  logic          tbl_vld_q [1:DEPTH];
  logic          tbl_vld_d [1:DEPTH];
  logic [AW-1:0] tbl_rd_q  [1:DEPTH];
  logic [AW-1:0] tbl_rd_d  [1:DEPTH];
  logic          tbl_ld_q  [1:DEPTH];
  logic          tbl_ld_d  [1:DEPTH];

  logic          ld_stall;
  logic          busy;
  logic          stall_d_int;
  logic          enter;
  logic [FW-1:0] fwd_a_sel;
  logic [FW-1:0] fwd_b_sel;

  // Load-use detection: an entry at stage k whose result becomes available
  // later than k+1 cannot reach E in time for the decode instruction.
  always_comb begin
    ld_stall = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (tbl_vld_q[k] && ((tbl_ld_q[k] ? LOAD_AVAIL : 32'd2) > k + 1)) begin
        if (rs1_d != '0 && rs1_d == tbl_rd_q[k]) ld_stall = 1'b1;
        if (rs2_d != '0 && rs2_d == tbl_rd_q[k]) ld_stall = 1'b1;
      end
    end
  end

  // Youngest match wins: scan oldest to youngest so the smallest k is
  // assigned last.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int unsigned k = DEPTH; k >= 2; k--) begin
      if (tbl_vld_q[k] && rs1_e != '0 && tbl_rd_q[k] == rs1_e) fwd_a_sel = FW'(k - 1);
      if (tbl_vld_q[k] && rs2_e != '0 && tbl_rd_q[k] == rs2_e) fwd_b_sel = FW'(k - 1);
    end
  end

`ifdef HAZARD_SB_MULTICYCLE_EN
  localparam int unsigned MCW = $clog2(MC_LAT);

  logic [MCW-1:0] mc_cnt_q;
  logic [MCW-1:0] mc_cnt_d;
  logic           mc_enter;

  assign busy     = (mc_cnt_q != '0);
  assign mc_enter = issue_valid & mc_d & ~stall_d_int & ~pcsrc_e & ~busy;

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (mc_enter)  mc_cnt_d = MCW'(MC_LAT - 1);
    else if (busy) mc_cnt_d = mc_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) mc_cnt_q <= '0;
    else      mc_cnt_q <= mc_cnt_d;
  end
`else
  logic unused_mc;

  assign unused_mc = mc_d;
  assign busy      = 1'b0;
`endif

  assign stall_d_int = (ld_stall | busy) & ~pcsrc_e;
  assign enter       = issue_valid & regwrite_d & (rd_d != '0) & ~stall_d_int & ~pcsrc_e;

  // Table advance. While E is held, the E entry stays put and a bubble
  // is inserted at M; older entries keep draining.
  always_comb begin
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      tbl_vld_d[k] = tbl_vld_q[k];
      tbl_rd_d[k]  = tbl_rd_q[k];
      tbl_ld_d[k]  = tbl_ld_q[k];
    end
    if (!busy) begin
      for (int unsigned k = DEPTH; k >= 2; k--) begin
        tbl_vld_d[k] = tbl_vld_q[k-1];
        tbl_rd_d[k]  = tbl_rd_q[k-1];
        tbl_ld_d[k]  = tbl_ld_q[k-1];
      end
      tbl_vld_d[1] = enter;
      tbl_rd_d[1]  = rd_d;
      tbl_ld_d[1]  = load_d;
    end else begin
      for (int unsigned k = DEPTH; k >= 3; k--) begin
        tbl_vld_d[k] = tbl_vld_q[k-1];
        tbl_rd_d[k]  = tbl_rd_q[k-1];
        tbl_ld_d[k]  = tbl_ld_q[k-1];
      end
      tbl_vld_d[2] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        tbl_vld_q[k] <= 1'b0;
        tbl_rd_q[k]  <= '0;
        tbl_ld_q[k]  <= 1'b0;
      end
    end else begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        tbl_vld_q[k] <= tbl_vld_d[k];
        tbl_rd_q[k]  <= tbl_rd_d[k];
        tbl_ld_q[k]  <= tbl_ld_d[k];
      end
    end
  end

  // Every output is held low while reset is asserted.
  assign stall_f = rst & stall_d_int;
  assign stall_d = rst & stall_d_int;
  assign flush_d = rst & pcsrc_e;
  assign flush_e = rst & (pcsrc_e | (ld_stall & ~busy));
  assign stall_e = rst & busy;
  assign mc_busy = rst & busy;
  assign fwd_a_e = rst ? fwd_a_sel : '0;
  assign fwd_b_e = rst ? fwd_b_sel : '0;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       regwrite_d, load_d, mc_d;
  logic [4:0] rs1_e, rs2_e;
  logic       pcsrc_e;

  logic       stall_f, stall_d, flush_d, flush_e, stall_e, mc_busy;
  logic [1:0] fwd_a_e, fwd_b_e;

  logic       stall_f1, stall_d1, flush_d1, flush_e1, stall_e1, mc_busy1;
  logic [2:0] fwd_a_e1, fwd_b_e1;

  int n_checks;
  int n_fail;

  hazard_scoreboard u0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d), .mc_d(mc_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .pcsrc_e(pcsrc_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stall_e(stall_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mc_busy(mc_busy)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_AVAIL(4)) u1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d), .mc_d(mc_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .pcsrc_e(pcsrc_e),
    .stall_f(stall_f1), .stall_d(stall_d1), .flush_d(flush_d1), .flush_e(flush_e1),
    .stall_e(stall_e1), .fwd_a_e(fwd_a_e1), .fwd_b_e(fwd_b_e1), .mc_busy(mc_busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_dec(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic rw, input logic ld, input logic mc);
    issue_valid = v; rs1_d = s1; rs2_d = s2; rd_d = d;
    regwrite_d = rw; load_d = ld; mc_d = mc;
  endtask

  // Advance to the next negedge; inputs set after this apply to the coming posedge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      set_dec(0, 0, 0, 0, 0, 0, 0);
      rs1_e = '0; rs2_e = '0; pcsrc_e = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    set_dec(1, 5'd3, 5'd4, 5'd3, 1, 1, 1);
    pcsrc_e = 1'b1;
    #1;
    n_checks++; if (flush_d !== 1'b0) begin n_fail++; $display("FAIL rst_flush_d: got %b exp 0", flush_d); end
    n_checks++; if (flush_e !== 1'b0) begin n_fail++; $display("FAIL rst_flush_e: got %b exp 0", flush_e); end
    step();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    pcsrc_e = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if ({stall_f, stall_d, stall_e, mc_busy} !== 4'b0) begin n_fail++; $display("FAIL rst_stalls: got %b exp 0000", {stall_f, stall_d, stall_e, mc_busy}); end
    n_checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0) begin n_fail++; $display("FAIL rst_fwd: got %b exp 0000", {fwd_a_e, fwd_b_e}); end
  endtask

  task automatic test_alu_chain();
    step(); set_dec(1, 0, 0, 5'd5, 1, 0, 0); #1;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL alu_c0_stall: got %b exp 0", stall_d); end
    step(); set_dec(1, 5'd5, 0, 5'd7, 1, 0, 0); #1;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL alu_c1_stall: got %b exp 0", stall_d); end
    step(); set_dec(1, 5'd5, 0, 5'd8, 1, 0, 0); rs1_e = 5'd5; #1;
    n_checks++; if (fwd_a_e !== 2'd1) begin n_fail++; $display("FAIL alu_fwd_m: got %0d exp 1", fwd_a_e); end
    step(); set_dec(0, 0, 0, 0, 0, 0, 0); rs1_e = 5'd5; rs2_e = 5'd7; #1;
    n_checks++; if (fwd_a_e !== 2'd2) begin n_fail++; $display("FAIL alu_fwd_w: got %0d exp 2", fwd_a_e); end
    n_checks++; if (fwd_b_e !== 2'd1) begin n_fail++; $display("FAIL alu_fwd_b_m: got %0d exp 1", fwd_b_e); end
    idle(6);
  endtask

  task automatic test_load_use();
    step(); set_dec(1, 0, 0, 5'd6, 1, 1, 0); #1;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL lu_c0_stall: got %b exp 0", stall_d); end
    step(); set_dec(1, 5'd6, 0, 5'd9, 1, 0, 0); #1;
    n_checks++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin n_fail++; $display("FAIL lu_stall: got %b exp 111", {stall_f, stall_d, flush_e}); end
    n_checks++; if (stall_e !== 1'b0) begin n_fail++; $display("FAIL lu_stall_e: got %b exp 0", stall_e); end
    n_checks++; if (stall_d1 !== 1'b1) begin n_fail++; $display("FAIL lu5_stall1: got %b exp 1", stall_d1); end
    step(); #1;
    n_checks++; if ({stall_d, flush_e} !== 2'b00) begin n_fail++; $display("FAIL lu_release: got %b exp 00", {stall_d, flush_e}); end
    n_checks++; if ({stall_d1, flush_e1} !== 2'b11) begin n_fail++; $display("FAIL lu5_stall2: got %b exp 11", {stall_d1, flush_e1}); end
    step(); rs1_e = 5'd6; #1;
    n_checks++; if (fwd_a_e !== 2'd2) begin n_fail++; $display("FAIL lu_fwd: got %0d exp 2", fwd_a_e); end
    n_checks++; if (stall_d1 !== 1'b0) begin n_fail++; $display("FAIL lu5_release: got %b exp 0", stall_d1); end
    step(); set_dec(0, 0, 0, 0, 0, 0, 0); rs1_e = 5'd6; #1;
    n_checks++; if (fwd_a_e1 !== 3'd3) begin n_fail++; $display("FAIL lu5_fwd: got %0d exp 3", fwd_a_e1); end
    idle(6);
  endtask

  task automatic test_branch();
    step(); set_dec(1, 0, 0, 5'd6, 1, 1, 0);
    step(); set_dec(1, 5'd6, 0, 5'd9, 1, 1, 0); pcsrc_e = 1'b1; #1;
    n_checks++; if ({flush_d, flush_e} !== 2'b11) begin n_fail++; $display("FAIL br_flush: got %b exp 11", {flush_d, flush_e}); end
    n_checks++; if ({stall_f, stall_d} !== 2'b00) begin n_fail++; $display("FAIL br_stall: got %b exp 00", {stall_f, stall_d}); end
    step(); set_dec(1, 5'd9, 0, 0, 0, 0, 0); pcsrc_e = 1'b0; #1;
    n_checks++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL br_e1_invalid: got %b exp 0", stall_d); end
    step(); set_dec(0, 0, 0, 0, 0, 0, 0); rs1_e = 5'd9; #1;
    n_checks++; if (fwd_a_e !== 2'd0) begin n_fail++; $display("FAIL br_fwd: got %0d exp 0", fwd_a_e); end
    idle(6);
  endtask

  task automatic test_x0();
    step(); set_dec(1, 0, 0, 5'd0, 1, 1, 0);
    step(); set_dec(1, 5'd0, 5'd0, 5'd0, 1, 1, 0); #1;
    n_checks++; if ({stall_d, flush_e} !== 2'b00) begin n_fail++; $display("FAIL x0_stall: got %b exp 00", {stall_d, flush_e}); end
    step(); set_dec(0, 0, 0, 0, 0, 0, 0); rs1_e = 5'd0; rs2_e = 5'd0; #1;
    n_checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0) begin n_fail++; $display("FAIL x0_fwd: got %b exp 0000", {fwd_a_e, fwd_b_e}); end
    idle(6);
  endtask

  // Two multi-cycle ops back to back: the second waits in decode, then
  // enters E as soon as the first is done and starts its own count.
  task automatic test_multicycle();
    logic exp_b;
`ifdef HAZARD_SB_MULTICYCLE_EN
    exp_b = 1'b1;
`else
    exp_b = 1'b0;
`endif
    step(); set_dec(1, 0, 0, 5'd10, 1, 0, 1); #1;
    n_checks++; if (mc_busy !== 1'b0) begin n_fail++; $display("FAIL mc_c0_busy: got %b exp 0", mc_busy); end
    for (int c = 1; c <= 3; c++) begin
      step(); set_dec(1, 0, 0, 5'd11, 1, 0, 1); #1;
      n_checks++; if ({stall_e, stall_f, stall_d, mc_busy} !== {4{exp_b}}) begin n_fail++; $display("FAIL mc_busy_c%0d: got %b exp %b", c, {stall_e, stall_f, stall_d, mc_busy}, {4{exp_b}}); end
      n_checks++; if (flush_e !== 1'b0) begin n_fail++; $display("FAIL mc_flush_c%0d: got %b exp 0", c, flush_e); end
    end
`ifdef HAZARD_SB_MULTICYCLE_EN
    step(); rs1_e = 5'd10; #1;
    n_checks++; if ({stall_e, stall_d, mc_busy} !== 3'b000) begin n_fail++; $display("FAIL mc_done: got %b exp 000", {stall_e, stall_d, mc_busy}); end
    n_checks++; if (fwd_a_e !== 2'd0) begin n_fail++; $display("FAIL mc_m_bubble: got %0d exp 0", fwd_a_e); end
    step(); set_dec(0, 0, 0, 0, 0, 0, 0); rs1_e = 5'd10; #1;
    n_checks++; if (fwd_a_e !== 2'd1) begin n_fail++; $display("FAIL mc_reach_m: got %0d exp 1", fwd_a_e); end
    n_checks++; if ({stall_e, mc_busy} !== 2'b11) begin n_fail++; $display("FAIL mc_b2b_busy: got %b exp 11", {stall_e, mc_busy}); end
`endif
    idle(8);
  endtask

  task automatic test_reset_mid_mc();
    step(); set_dec(1, 0, 0, 5'd12, 1, 1, 1);
    step(); set_dec(0, 0, 0, 0, 0, 0, 0);
    step(); set_dec(1, 5'd12, 0, 5'd13, 1, 0, 0); rs1_e = 5'd12; pcsrc_e = 1'b1; rst = 1'b0; #1;
    n_checks++; if ({stall_f, stall_d, stall_e, mc_busy, flush_d, flush_e} !== 6'b0) begin n_fail++; $display("FAIL rmc_outs: got %b exp 000000", {stall_f, stall_d, stall_e, mc_busy, flush_d, flush_e}); end
    n_checks++; if (fwd_a_e !== 2'd0) begin n_fail++; $display("FAIL rmc_fwd: got %0d exp 0", fwd_a_e); end
    step(); rst = 1'b1; pcsrc_e = 1'b0; #1;
    n_checks++; if ({stall_d, stall_e, mc_busy} !== 3'b000) begin n_fail++; $display("FAIL rmc_after: got %b exp 000", {stall_d, stall_e, mc_busy}); end
    n_checks++; if (fwd_a_e !== 2'd0) begin n_fail++; $display("FAIL rmc_tbl_empty: got %0d exp 0", fwd_a_e); end
    idle(4);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; pcsrc_e = 1'b0; rs1_e = '0; rs2_e = '0;
    set_dec(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_chain();
    test_load_use();
    test_branch();
    test_x0();
    test_multicycle();
    test_reset_mid_mc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
